// File: rtl/gpi_rx_pkg.sv
// Shared constants and helpers for the ACK-strobed GPI receive FIFO.
package gpi_rx_pkg;

  localparam int ACK_FALLING = 0;
  localparam int ACK_RISING  = 1;

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/gpi_rx_sync_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through head and occupancy count.
module gpi_rx_sync_fifo
  import gpi_rx_pkg::*;
#(
  parameter int DATA_W = 23,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic [DATA_W-1:0]           wdata,
  input  logic                        pop,
  output logic [DATA_W-1:0]           rdata,
  output logic                        valid,
  output logic                        full,
  output logic [count_w(DEPTH)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_nxt_ptr;
  logic [CW-1:0]     count_next;
  logic [DATA_W-1:0] head_next;

  assign full       = (count == CW'(DEPTH));
  assign rd_nxt_ptr = rd_ptr + PW'(1);

  // Next occupancy and next head word; the head must track the entry behind it on a pop.
  always_comb begin
    count_next = count;
    head_next  = rdata;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    if (pop && (count > CW'(1))) begin
      head_next = mem[rd_nxt_ptr];
    end else if (push && ((count == CW'(0)) || (pop && (count == CW'(1))))) begin
      head_next = wdata;
    end else begin
      head_next = rdata;
    end
  end

  // Storage array; contents are don't-care after reset because the pointers restart.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, count and the registered head/valid outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      rdata  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_nxt_ptr;
      end
      count <= count_next;
      valid <= (count_next != CW'(0));
      rdata <= head_next;
    end
  end

endmodule

// File: rtl/gpi_rx_fifo.sv
// GPI capture receiver: synchronises the ACK strobe, captures gpi on the chosen edge
// and buffers the words on a valid/ready stream with a sticky overflow flag.
module gpi_rx_fifo
  import gpi_rx_pkg::*;
#(
  parameter int DATA_W      = 23,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_EDGE    = ACK_FALLING
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DATA_W-1:0]           gpi,
  input  logic                        ack,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [count_w(DEPTH)-1:0]   count,
  output logic                        overflow,
  input  logic                        ovf_clr
);

  // Reset level equals the post-edge level so leaving reset never looks like an edge.
  localparam logic EDGE_LVL = (ACK_EDGE == ACK_RISING) ? 1'b1 : 1'b0;

  logic [SYNC_STAGES-1:0] sync;
  logic                   ack_s;
  logic                   ack_d;
  logic                   cap;
  logic                   pop;
  logic                   push;
  logic                   full;
  logic                   ovf_set;

  assign ack_s   = sync[SYNC_STAGES-1];
  assign pop     = rx_valid & rx_ready;
  assign push    = cap & (~full | pop);
  assign ovf_set = cap & full & ~pop;

  // ACK synchroniser chain plus the one-cycle delay used for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync  <= {SYNC_STAGES{EDGE_LVL}};
      ack_d <= EDGE_LVL;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], ack};
      ack_d <= ack_s;
    end
  end

  // Single-cycle capture pulse on the selected edge of the synchronised strobe.
  always_comb begin
    cap = 1'b0;
    if (EDGE_LVL) begin
      cap = ack_s & ~ack_d;
    end else begin
      cap = ~ack_s & ack_d;
    end
  end

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end else begin
      overflow <= overflow;
    end
  end

  gpi_rx_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (gpi),
    .pop     (pop),
    .rdata   (rx_data),
    .valid   (rx_valid),
    .full    (full),
    .count   (count)
  );

endmodule
